// File: rtl/video_mem_arbiter.sv
// Shares one single-port RAM between the video fetch engine (strict priority, fixed 1-cycle latency)
// and the CPU valid/ready bus. Optional stall counter: define VIDEO_MEM_ARB_STATS_EN.
module video_mem_arbiter #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned STALL_W = 16
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               cpu_valid,
  input  logic               cpu_sel,
  input  logic [3:0]         cpu_wstrb,
  input  logic [31:0]        cpu_addr,
  input  logic [31:0]        cpu_wdata,
  output logic [31:0]        cpu_rdata,
  output logic               cpu_ready,
  input  logic               vid_req,
  input  logic [31:0]        vid_addr,
  output logic [31:0]        vid_rdata,
  output logic               vid_valid,
  output logic               ram_en,
  output logic [3:0]         ram_we,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [31:0]        ram_wdata,
  input  logic [31:0]        ram_rdata,
  output logic [STALL_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        cpu_ready_q, cpu_ready_d;
  logic        vid_valid_q;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic        cpu_req;
  logic        issue_cpu;
  logic        stall_inc;

  // Address bits outside the RAM word range are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0],
                              vid_addr[31:ADDR_W+2], vid_addr[1:0]};

  assign cpu_req = cpu_valid & cpu_sel & ~cpu_ready_q;

  always_comb begin
    state_d     = state_q;
    cpu_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    issue_cpu   = 1'b0;
    stall_inc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          if (vid_req) begin
            stall_inc = 1'b1;
          end else begin
            issue_cpu = 1'b1;
            state_d   = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cpu_rdata_d = ram_rdata;
        cpu_ready_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // RAM port is combinational; video always owns the port when it requests.
  always_comb begin
    ram_en    = n_reset & (vid_req | issue_cpu);
    ram_we    = (n_reset & issue_cpu) ? cpu_wstrb : 4'b0000;
    ram_addr  = vid_req ? vid_addr[ADDR_W+1:2] : cpu_addr[ADDR_W+1:2];
    ram_wdata = cpu_wdata;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= ST_IDLE;
      cpu_ready_q <= 1'b0;
      vid_valid_q <= 1'b0;
      cpu_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cpu_ready_q <= cpu_ready_d;
      vid_valid_q <= vid_req;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  assign cpu_ready = cpu_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign vid_valid = vid_valid_q;
  assign vid_rdata = ram_rdata;

`ifdef VIDEO_MEM_ARB_STATS_EN
  logic [STALL_W-1:0] stall_q;

  // Saturating count of IDLE cycles the CPU lost to a colliding video request.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      stall_q <= '0;
    end else if (stall_inc && (stall_q != {STALL_W{1'b1}})) begin
      stall_q <= stall_q + STALL_W'(1);
    end
  end

  assign stall_count = stall_q;
`else
  logic unused_stall;
  assign unused_stall = stall_inc;
  assign stall_count  = '0;
`endif

endmodule
